signal_event_tracker: RTL and testbench

- Timestamped history recorder for one pipeline control signal. Used by the ID/EX trace trackers alongside trace_buffer and advanced_signal_tracker.
- Every qualifying cycle in which the tracked signal is asserted is logged with the free-running cycle counter value.
- Consumers later ask whether the signal fired inside a past time window (range query), or when it first fired in that window (single-cycle query).

---
 rtl/signal_event_tracker.sv | 106 ++++++++++
 tb/tb_signal_event_tracker.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/signal_event_tracker.sv
// Timestamped history recorder for one pipeline control signal.
// Logs the cycle counter on every qualifying assertion and answers window queries over the log.
module signal_event_tracker #(
    parameter int DATA_WIDTH  = 1,
    parameter int BUFFER_SIZE = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic signed [31:0]    counter,
    input  logic [DATA_WIDTH-1:0] tracked_signal,
    input  logic                  ready_flag,
    input  logic                  ex_ready_flag,
    input  logic                  data_mem_req_flag,
    input  logic signed [31:0]    range_in [2],
    input  logic                  recalculate_range,
    output logic                  range_out,
    input  logic                  recalculate_single_cycle,
    output logic signed [31:0]    single_cycle_out
);

    localparam int PTR_W = $clog2(BUFFER_SIZE);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(BUFFER_SIZE);

    logic signed [31:0]     ts_mem_q [BUFFER_SIZE];
    logic [BUFFER_SIZE-1:0] valid_q, valid_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   range_q, range_d;
    logic signed [31:0]     single_q, single_d;

    logic                   record_en;
    logic signed [31:0]     win_lo, win_hi;
    logic                   range_hit;
    logic                   single_found;
    logic signed [31:0]     single_min;

    assign record_en = (|tracked_signal) && (ready_flag || ex_ready_flag || data_mem_req_flag);
    assign win_lo    = range_in[1];
    assign win_hi    = range_in[0];

    // Window search over the stored slots only; this cycle's write is not yet visible.
    always_comb begin
        range_hit    = 1'b0;
        single_found = 1'b0;
        single_min   = -32'sd1;
        for (int i = 0; i < BUFFER_SIZE; i++) begin
            if (valid_q[i] && (ts_mem_q[i] >= win_lo) && (ts_mem_q[i] <= win_hi)) begin
                range_hit = 1'b1;
                if (!single_found || (ts_mem_q[i] < single_min)) begin
                    single_min   = ts_mem_q[i];
                    single_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        valid_d  = valid_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        range_d  = range_q;
        single_d = single_q;
        if (record_en) begin
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
            if (count_q != FULL_COUNT) begin
                count_d = count_q + CNT_W'(1);
            end
        end
        if (recalculate_range) begin
            range_d = range_hit;
        end
        if (recalculate_single_cycle) begin
            single_d = single_found ? single_min : -32'sd1;
        end
    end

    // Results pass straight through while a strobe is high, then the registered copy holds.
    assign range_out        = recalculate_range        ? range_d  : range_q;
    assign single_cycle_out = recalculate_single_cycle ? single_d : single_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q  <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            range_q  <= 1'b0;
            single_q <= -32'sd1;
        end else begin
            valid_q  <= valid_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            range_q  <= range_d;
            single_q <= single_d;
        end
    end

    // NOTE: the timestamp array has no reset; per-slot valid bits make stale contents unreachable.
    always_ff @(posedge clk) begin
        if (record_en) begin
            ts_mem_q[wr_ptr_q] <= counter;
        end
    end

endmodule

// File: tb/tb_signal_event_tracker.sv
// Randomized and directed bench for signal_event_tracker against a queue-based history model.
module tb_signal_event_tracker;

    localparam int BUF = 128;

    logic               clk;
    logic               rst;
    logic signed [31:0] counter;
    logic [0:0]         tracked_signal;
    logic               ready_flag;
    logic               ex_ready_flag;
    logic               data_mem_req_flag;
    logic signed [31:0] range_in [2];
    logic               recalculate_range;
    logic               range_out;
    logic               recalculate_single_cycle;
    logic signed [31:0] single_cycle_out;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: the last BUF logged timestamps plus the two held results.
    int hist [$];
    int hold_r = 0;
    int hold_s = -1;

    signal_event_tracker #(.DATA_WIDTH(1), .BUFFER_SIZE(BUF)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .counter                  (counter),
        .tracked_signal           (tracked_signal),
        .ready_flag               (ready_flag),
        .ex_ready_flag            (ex_ready_flag),
        .data_mem_req_flag        (data_mem_req_flag),
        .range_in                 (range_in),
        .recalculate_range        (recalculate_range),
        .range_out                (range_out),
        .recalculate_single_cycle (recalculate_single_cycle),
        .single_cycle_out         (single_cycle_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    endtask

    function automatic int model_range(input int lo, input int hi);
        foreach (hist[i]) if (hist[i] >= lo && hist[i] <= hi) return 1;
        return 0;
    endfunction

    function automatic int model_min(input int lo, input int hi);
        int m = -1;
        bit found = 0;
        foreach (hist[i]) begin
            if (hist[i] >= lo && hist[i] <= hi && (!found || hist[i] < m)) begin
                m = hist[i];
                found = 1;
            end
        end
        return m;
    endfunction

    // One clock: check outputs at the negedge, advance the model, then step past the posedge.
    task automatic tick();
        int exp_r;
        int exp_s;
        @(negedge clk);
        exp_r = recalculate_range ? model_range(range_in[1], range_in[0]) : hold_r;
        exp_s = recalculate_single_cycle ? model_min(range_in[1], range_in[0]) : hold_s;
        check("range_out", int'(range_out), exp_r);
        check("single_cycle_out", single_cycle_out, exp_s);
        if (rst) begin
            if (recalculate_range) hold_r = exp_r;
            if (recalculate_single_cycle) hold_s = exp_s;
            if (tracked_signal != 0 && (ready_flag || ex_ready_flag || data_mem_req_flag)) begin
                hist.push_back(counter);
                if (hist.size() > BUF) hist.delete(0);
            end
        end
        @(posedge clk);
        #1;
        counter = counter + 1;
    endtask

    // Both strobes on a window, checked against fixed expected values, then one model-checked clock.
    task automatic query_expect(input string tag, input int lo, input int hi,
                                input int exp_r, input int exp_s);
        tracked_signal           = 1'b0;
        range_in[1]              = lo;
        range_in[0]              = hi;
        recalculate_range        = 1'b1;
        recalculate_single_cycle = 1'b1;
        #1;
        check({tag, "_range"}, int'(range_out), exp_r);
        check({tag, "_single"}, single_cycle_out, exp_s);
        tick();
        recalculate_range        = 1'b0;
        recalculate_single_cycle = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        counter = 0;
        tracked_signal = 1'b0;
        ready_flag = 1'b0;
        ex_ready_flag = 1'b0;
        data_mem_req_flag = 1'b0;
        range_in[0] = 0;
        range_in[1] = 0;
        recalculate_range = 1'b0;
        recalculate_single_cycle = 1'b0;
        #23;
        check("reset_range", int'(range_out), 0);
        check("reset_single", single_cycle_out, -1);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Pulses at 10, 11 and 20 with ready_flag.
        counter = 10;
        tracked_signal = 1'b1;
        ready_flag = 1'b1;
        tick();
        tick();
        tracked_signal = 1'b0;
        while (counter < 20) tick();
        tracked_signal = 1'b1;
        tick();
        tracked_signal = 1'b0;
        ready_flag = 1'b0;
        query_expect("gap", 12, 19, 0, -1);
        query_expect("span", 11, 20, 1, 11);
        query_expect("point_hit", 20, 20, 1, 20);
        query_expect("point_miss", 21, 21, 0, -1);
        range_in[1] = 0;
        range_in[0] = 100;
        for (int i = 0; i < 3; i++) tick();
        check("hold_range", int'(range_out), 0);
        check("hold_single", single_cycle_out, -1);

        // Unqualified assertion, then data_mem_req_flag only.
        counter = 30;
        tracked_signal = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        query_expect("no_flags", 30, 34, 0, -1);
        counter = 30;
        tracked_signal = 1'b1;
        data_mem_req_flag = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        data_mem_req_flag = 1'b0;
        query_expect("dmr_flag", 30, 34, 1, 30);

        // Continuous assertion overflowing the buffer.
        counter = 100;
        tracked_signal = 1'b1;
        ready_flag = 1'b1;
        for (int i = 0; i < 130; i++) tick();
        ready_flag = 1'b0;
        query_expect("overwritten", 100, 101, 0, -1);
        query_expect("retained", 102, 229, 1, 102);

        // Inverted window, then record and query in the same cycle.
        counter = 45;
        tracked_signal = 1'b1;
        ex_ready_flag = 1'b1;
        tick();
        ex_ready_flag = 1'b0;
        query_expect("inverted", 50, 40, 0, -1);
        counter = 60;
        tracked_signal = 1'b1;
        ready_flag = 1'b1;
        range_in[1] = 60;
        range_in[0] = 60;
        recalculate_range = 1'b1;
        recalculate_single_cycle = 1'b1;
        #1;
        check("same_cycle_range", int'(range_out), 0);
        check("same_cycle_single", single_cycle_out, -1);
        tick();
        ready_flag = 1'b0;
        query_expect("next_cycle", 60, 60, 1, 60);

        // Random traffic with windows around the recent counter values.
        for (int i = 0; i < 400; i++) begin
            int lo;
            tracked_signal           = 1'($urandom_range(0, 1));
            ready_flag               = ($urandom_range(0, 3) == 0);
            ex_ready_flag            = ($urandom_range(0, 3) == 0);
            data_mem_req_flag        = ($urandom_range(0, 3) == 0);
            recalculate_range        = 1'($urandom_range(0, 1));
            recalculate_single_cycle = 1'($urandom_range(0, 1));
            lo = counter - int'($urandom_range(0, 200));
            range_in[1] = lo;
            range_in[0] = lo + int'($urandom_range(0, 65)) - 5;
            if ($urandom_range(0, 15) == 0) counter = counter - 300;
            tick();
        end
        tracked_signal = 1'b0;
        ready_flag = 1'b0;
        ex_ready_flag = 1'b0;
        data_mem_req_flag = 1'b0;
        recalculate_range = 1'b0;
        recalculate_single_cycle = 1'b0;

        // Log at 5, then asynchronous reset in the middle of a cycle.
        counter = 5;
        tracked_signal = 1'b1;
        ready_flag = 1'b1;
        tick();
        ready_flag = 1'b0;
        query_expect("pre_reset", 5, 5, 1, 5);
        #2;
        rst = 1'b0;
        #1;
        check("async_reset_range", int'(range_out), 0);
        check("async_reset_single", single_cycle_out, -1);
        hist.delete();
        hold_r = 0;
        hold_s = -1;
        @(negedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        tick();
        query_expect("post_reset", 0, 10, 0, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
